pio_edge_irq_in: RTL and testbench



---
 rtl/pio_edge_irq_pkg.sv | 15 +
 rtl/pio_edge_irq_cond.sv | 60 ++++++
 rtl/pio_edge_irq_in.sv | 121 ++++++++++++
 tb/tb_pio_edge_irq_in.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_irq_pkg.sv
// pio_edge_irq_pkg
//   Shared constants for the edge-capturing input PIO: Avalon word address
//   width and the register map offsets decoded by pio_edge_irq_in.
package pio_edge_irq_pkg;

  localparam int ADDR_W = 3;

  // Register map (word offsets). Offsets 5..7 read as zero, writes ignored.
  localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;  // RO  conditioned inputs
  localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd1;  // RW  rise-enable
  localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;  // RW  irq mask
  localparam logic [ADDR_W-1:0] ADDR_CAPT = 3'd3;  // R / W1C edge capture
  localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd4;  // RW  fall-enable

endpackage

// File: rtl/pio_edge_irq_cond.sv
// pio_edge_irq_cond
//   Single-bit input conditioner: SYNC_STAGES-deep synchroniser, optionally
//   followed by a debounce filter (macro PIO_EDGE_IRQ_DEBOUNCE_EN).
//   Ports:
//     clk   in  system clock
//     reset in  asynchronous active-high reset
//     d     in  asynchronous input bit
//     cond  out conditioned (synchronised, optionally debounced) bit
//   With PIO_EDGE_IRQ_DEBOUNCE_EN undefined, cond is the last synchroniser
//   flop and no counter exists.
module pio_edge_irq_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic cond
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
  // cond flips on the DEBOUNCE_CYCLES-th consecutive clock on which the
  // synchronised value disagrees with it; any agreement restarts the count.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_cond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_cond <= 1'b0;
    end else if (w_sync != r_cond) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt  <= '0;
        r_cond <= w_sync;
      end else begin
        r_cnt  <= r_cnt + 16'd1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign cond = r_cond;
`else
  assign cond = w_sync;
`endif

endmodule

// File: rtl/pio_edge_irq_in.sv
// pio_edge_irq_in
//   Edge-capturing input PIO, Avalon-MM slave with one-cycle read latency.
//   Each in_port bit is synchronised (optionally debounced), edge-detected,
//   latched into a write-1-to-clear CAPTURE register and OR-reduced through
//   IRQ_MASK into a registered level interrupt.
//   Optional feature macro: PIO_EDGE_IRQ_DEBOUNCE_EN (per-bit debounce).
//   Ports:
//     clk        in  system clock
//     reset      in  asynchronous active-high reset
//     address    in  [2:0] word address
//     chipselect in  slave select
//     write_n    in  active-low write strobe
//     writedata  in  [31:0] write data (only [WIDTH-1:0] used)
//     readdata   out [31:0] registered read data, zero above WIDTH
//     in_port    in  [WIDTH-1:0] asynchronous inputs
//     irq        out registered level interrupt
//   Bus handshake: a write is accepted on any clock where chipselect=1 and
//   write_n=0 (no wait states). readdata always reflects the register
//   addressed on the previous clock, independent of chipselect.
module pio_edge_irq_in
  import pio_edge_irq_pkg::*;
#(
  parameter int               WIDTH           = 16,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0] RISE_RESET      = '1,
  parameter logic [WIDTH-1:0] FALL_RESET      = '0,
  parameter int               DEBOUNCE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] w_cond;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_unused_wdata;
  logic [31:0]      w_rd_word;
  logic             w_wr;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capt;
  logic [31:0]      r_readdata;
  logic             r_irq;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cond
    pio_edge_irq_cond #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .d    (in_port[g]),
      .cond (w_cond[g])
    );
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = writedata;

  assign w_rise = w_cond & ~r_prev;
  assign w_fall = ~w_cond & r_prev;
  assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr  = (w_wr && address == ADDR_CAPT) ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_rise_en <= RISE_RESET;
      r_fall_en <= FALL_RESET;
      r_mask    <= '0;
      r_capt    <= '0;
    end else begin
      r_prev <= w_cond;
      // A new edge wins over a simultaneous clear so it is never lost.
      r_capt <= w_set | (r_capt & ~w_clr);
      if (w_wr && address == ADDR_RISE) r_rise_en <= w_wdata;
      if (w_wr && address == ADDR_MASK) r_mask    <= w_wdata;
      if (w_wr && address == ADDR_FALL) r_fall_en <= w_wdata;
    end
  end

  always_comb begin
    w_rd_word = '0;
    case (address)
      ADDR_DATA: w_rd_word = 32'(w_cond);
      ADDR_RISE: w_rd_word = 32'(r_rise_en);
      ADDR_MASK: w_rd_word = 32'(r_mask);
      ADDR_CAPT: w_rd_word = 32'(r_capt);
      ADDR_FALL: w_rd_word = 32'(r_fall_en);
      default:   w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_word;
      r_irq      <= |(r_capt & r_mask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// tb_pio_edge_irq_in
//   Directed bench for pio_edge_irq_in (WIDTH=16, SYNC_STAGES=2). When built
//   with PIO_EDGE_IRQ_DEBOUNCE_EN the DUT gets DEBOUNCE_CYCLES=8, latencies
//   are stretched accordingly and the glitch/pulse steps are added.
module tb_pio_edge_irq_in;

  localparam int DBC = 8;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pio_edge_irq_in #(
    .WIDTH          (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk); #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    cycles(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    cycles(2);

    // Register reset values
    bus_read(3'd0, rd); check("rst_data", rd, 32'h0000_0000);
    bus_read(3'd1, rd); check("rst_rise", rd, 32'h0000_FFFF);
    bus_read(3'd2, rd); check("rst_mask", rd, 32'h0000_0000);
    bus_read(3'd3, rd); check("rst_capt", rd, 32'h0000_0000);
    bus_read(3'd4, rd); check("rst_fall", rd, 32'h0000_0000);
    bus_read(3'd6, rd); check("rst_off6", rd, 32'h0000_0000);
    check("rst_irq_idle", {31'b0, irq}, 32'h0);

    // Rising edges on bits 0 and 2, mask bit 0; latency check
    bus_write(3'd2, 32'h0000_0001);
    bus_read(3'd2, rd); check("mask_rb", rd, 32'h0000_0001);
    address = 3'd3;
    in_port = 16'h0005;
    cycles(3 + DB);
    check("capt_lat_before", readdata, 32'h0);
    check("irq_lat_before", {31'b0, irq}, 32'h0);
    cycles(1);
    check("capt_lat_after", readdata, 32'h0000_0005);
    check("irq_lat_after", {31'b0, irq}, 32'h1);
    bus_read(3'd0, rd); check("data_5", rd, 32'h0000_0005);

    // W1C: clearing an unmasked bit keeps irq, clearing the masked bit drops it
    bus_write(3'd3, 32'h0000_0004);
    bus_read(3'd3, rd); check("w1c_part", rd, 32'h0000_0001);
    check("irq_kept", {31'b0, irq}, 32'h1);
    bus_write(3'd3, 32'h0000_0001);
    check("irq_clr_edge", {31'b0, irq}, 32'h1);
    cycles(1);
    check("irq_clr_next", {31'b0, irq}, 32'h0);
    bus_read(3'd3, rd); check("w1c_all", rd, 32'h0);

    // Falling-edge only on bit 1
    bus_write(3'd1, 32'h0);
    bus_write(3'd4, 32'h0000_0002);
    in_port = 16'h0007;
    cycles(4 + DB);
    bus_read(3'd3, rd); check("fall_no_rise", rd, 32'h0);
    in_port = 16'h0005;
    cycles(4 + DB);
    bus_read(3'd3, rd); check("fall_bit1", rd, 32'h0000_0002);
    check("fall_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(3'd3, 32'h0000_0002);

    // Edge and clear on the same clock: edge wins
    bus_write(3'd1, 32'h0000_0001);
    bus_write(3'd4, 32'h0);
    in_port = 16'h0004;
    cycles(4 + DB);
    bus_read(3'd3, rd); check("pre_collide", rd, 32'h0);
    in_port = 16'h0005;
    cycles(2 + DB);
    bus_write(3'd3, 32'h0000_0001);
    bus_read(3'd3, rd); check("collide_set_wins", rd, 32'h0000_0001);
    check("collide_irq", {31'b0, irq}, 32'h1);

    // Disabling enable keeps captured bits; mask drop clears irq one clock later
    bus_write(3'd1, 32'h0);
    bus_read(3'd3, rd); check("disable_keeps", rd, 32'h0000_0001);
    bus_write(3'd2, 32'h0);
    check("mask_clr_edge", {31'b0, irq}, 32'h1);
    cycles(1);
    check("mask_clr_next", {31'b0, irq}, 32'h0);

    // Unmapped offset and upper-bit handling
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd); check("off6_ignored", rd, 32'h0);
    bus_read(3'd1, rd); check("rise_untouched", rd, 32'h0);
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, rd); check("rise_width", rd, 32'h0000_FFFF);

    // Mid-operation reset with inputs held high
    address = 3'd3;
    reset   = 1'b1;
    #1;
    check("async_rst_rd", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    cycles(2);
    reset = 1'b0;
    cycles(6 + DB);
    bus_read(3'd3, rd); check("post_rst_edge", rd, 32'h0000_0005);
    bus_read(3'd0, rd); check("post_rst_data", rd, 32'h0000_0005);
    bus_read(3'd4, rd); check("post_rst_fall", rd, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    // Debounce: short glitch is filtered, long pulse captured after D+3 clocks
    bus_write(3'd3, 32'h0000_FFFF);
    in_port = 16'h0105;
    cycles(5);
    in_port = 16'h0005;
    cycles(20);
    bus_read(3'd3, rd); check("glitch_capt", rd, 32'h0);
    bus_read(3'd0, rd); check("glitch_data", rd, 32'h0000_0005);
    address = 3'd3;
    in_port = 16'h0105;
    cycles(DBC + 3);
    check("pulse_before", readdata, 32'h0);
    cycles(1);
    check("pulse_capt", readdata, 32'h0000_0100);
    cycles(8);
    in_port = 16'h0005;
    cycles(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
